// File: rtl/ahbl_apb_bridge_mslot.sv
// AHB-Lite slave to APB3 master bridge with up to 16 decoded APB slots,
// PREADY wait states, PSLVERR/unmapped error responses and optional PREADY timeout.
module ahbl_apb_bridge_mslot #(
  parameter int NUM_SLOTS = 16,
  parameter int SLOT_LSB  = 8,
  parameter int TIMEOUT   = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESETN,
  input  logic                 HSEL,
  input  logic [31:0]          HADDR,
  input  logic                 HWRITE,
  input  logic [1:0]           HTRANS,
  input  logic [2:0]           HSIZE,
  input  logic [31:0]          HWDATA,
  input  logic                 HREADYIN,
  output logic [31:0]          HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP,
  output logic [NUM_SLOTS-1:0] PSEL,
  output logic [31:0]          PADDR,
  output logic                 PWRITE,
  output logic                 PENABLE,
  output logic [31:0]          PWDATA,
  input  logic [31:0]          PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_DPHASE, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
  } state_e;

  state_e               state_q, state_d;
  logic                 hreadyout_q, hreadyout_d;
  logic                 hresp_q, hresp_d;
  logic [31:0]          hrdata_q, hrdata_d;
  logic [NUM_SLOTS-1:0] psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [31:0]          paddr_q, paddr_d;
  logic [31:0]          pwdata_q, pwdata_d;
  logic [31:0]          addr_q, addr_d;
  logic                 write_q, write_d;
  logic [3:0]           slot_q, slot_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 accept;
  logic                 unused_hsize;

  // Transfer size is irrelevant: every access moves a full word.
  assign unused_hsize = ^HSIZE;
  assign accept = HSEL & HREADYIN & HTRANS[1];

  always_comb begin
    state_d     = state_q;
    hrdata_d    = hrdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    addr_d      = addr_q;
    write_d     = write_q;
    slot_d      = slot_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR2: begin
        if (accept) begin
          state_d = S_DPHASE;
          addr_d  = HADDR;
          write_d = HWRITE;
          slot_d  = HADDR[SLOT_LSB+3:SLOT_LSB];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DPHASE: begin
        pwdata_d = HWDATA;
        if ({1'b0, slot_q} < 5'(NUM_SLOTS)) begin
          state_d  = S_SETUP;
          paddr_d  = addr_q;
          pwrite_d = write_q;
          for (int i = 0; i < NUM_SLOTS; i++) begin
            psel_d[i] = (slot_q == 4'(i));
          end
        end else begin
          state_d = S_ERR1;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        if (PREADY) begin
          psel_d    = '0;
          penable_d = 1'b0;
          cnt_d     = '0;
          if (PSLVERR) begin
            state_d = S_ERR1;
          end else begin
            state_d = S_DONE;
            if (!pwrite_q) hrdata_d = PRDATA;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
          // Counter value after this cycle equals the number of stalled cycles so far.
          if (TIMEOUT != 0 && ({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT)) begin
            state_d   = S_ERR1;
            psel_d    = '0;
            penable_d = 1'b0;
            cnt_d     = '0;
          end
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase

    hreadyout_d = (state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR2);
    hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      state_q     <= S_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      slot_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
    end
  end

  assign HRDATA    = hrdata_q;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign PSEL      = psel_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PENABLE   = penable_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_ahbl_apb_bridge_mslot.sv
// Self-checking bench for ahbl_apb_bridge_mslot: directed scenarios plus randomized
// transfers compared against a transfer-level reference model of the bridge.
module tb_ahbl_apb_bridge_mslot;

  localparam int NS  = 8;
  localparam int LSB = 8;
  localparam int TO  = 4;

  logic          HCLK = 1'b0;
  logic          HRESETN = 1'b0;
  logic          HSEL = 1'b0;
  logic [31:0]   HADDR = '0;
  logic          HWRITE = 1'b0;
  logic [1:0]    HTRANS = 2'b00;
  logic [2:0]    HSIZE = 3'b010;
  logic [31:0]   HWDATA = '0;
  logic          HREADYIN = 1'b1;
  logic [31:0]   HRDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic [NS-1:0] PSEL;
  logic [31:0]   PADDR;
  logic          PWRITE;
  logic          PENABLE;
  logic [31:0]   PWDATA;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_hrdata = '0;

  int          slv_waits = 0;
  logic        slv_stall = 1'b0;
  logic        slv_err = 1'b0;
  logic [31:0] slv_rdata = '0;
  int          acc_cnt = 0;

  typedef struct {
    int            low;
    logic          dphase_low;
    logic          resp_err_low;
    logic          resp_done;
    logic [NS-1:0] psel_or;
    int            pen_cycles;
    logic [31:0]   paddr;
    logic          pwrite;
    logic [31:0]   pwdata;
    logic [31:0]   hrdata;
    logic          hung;
  } obs_t;

  ahbl_apb_bridge_mslot #(.NUM_SLOTS(NS), .SLOT_LSB(LSB), .TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADYIN(HREADYIN),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .PSEL(PSEL),
    .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  // APB slave: holds PREADY low for slv_waits enable cycles, or forever when stalled.
  always @(posedge HCLK) begin
    if (PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end
  assign PREADY  = !slv_stall && (acc_cnt >= slv_waits);
  assign PSLVERR = slv_err && PREADY;
  assign PRDATA  = slv_rdata;

  function automatic obs_t model_xfer(input logic [31:0] addr, input logic wr,
                                      input logic [31:0] wd, input int waits,
                                      input logic stall, input logic err,
                                      input logic [31:0] rd);
    obs_t e;
    int   slot;
    e = '{default: 0};
    slot = int'(addr[LSB+3:LSB]);
    e.dphase_low = 1'b1;
    e.hrdata = model_hrdata;
    if (slot >= NS) begin
      e.low = 2;
      e.resp_err_low = 1'b1;
      e.resp_done = 1'b1;
    end else begin
      e.psel_or[slot] = 1'b1;
      e.paddr = addr;
      e.pwrite = wr;
      e.pwdata = wd;
      if (stall || waits >= TO) begin
        e.pen_cycles = TO;
        e.low = 3 + TO;
        e.resp_err_low = 1'b1;
        e.resp_done = 1'b1;
      end else begin
        e.pen_cycles = waits + 1;
        e.low = 3 + waits + (err ? 1 : 0);
        e.resp_err_low = err;
        e.resp_done = err;
        if (!err && !wr) e.hrdata = rd;
      end
    end
    return e;
  endfunction

  // Entered at a negedge in a cycle where the bridge can accept; returns at the
  // negedge of the completion cycle, so a following call lands back-to-back.
  task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                          input int waits, input logic stall, input logic err,
                          input logic [31:0] rd, output obs_t o);
    o = '{default: 0};
    slv_waits = waits;
    slv_stall = stall;
    slv_err = err;
    slv_rdata = rd;
    HSEL = 1'b1;
    HTRANS = 2'b10;
    HADDR = addr;
    HWRITE = wr;
    HREADYIN = 1'b1;
    @(negedge HCLK);
    HSEL = 1'($urandom_range(0, 1));
    HTRANS = 2'($urandom_range(0, 1));
    HADDR = $urandom;
    HWDATA = wd;
    o.dphase_low = !HREADYOUT;
    for (int n = 0; n < 64; n++) begin
      if (HREADYOUT) break;
      o.low++;
      o.resp_err_low = HRESP;
      if (PSEL != '0) begin
        o.psel_or |= PSEL;
        o.paddr = PADDR;
        o.pwrite = PWRITE;
        o.pwdata = PWDATA;
        if (PENABLE) o.pen_cycles++;
      end
      @(negedge HCLK);
    end
    o.hung = !HREADYOUT;
    o.resp_done = HRESP;
    o.hrdata = HRDATA;
  endtask

  task automatic test_reset();
    HRESETN = 1'b0;
    repeat (2) @(negedge HCLK);
    HRESETN = 1'b1;
    @(negedge HCLK);
    checks++; if (HREADYOUT !== 1'b1) begin failures++; $display("[TB] FAIL reset_hreadyout: got %b expected 1", HREADYOUT); end
    checks++; if (HRESP !== 1'b0) begin failures++; $display("[TB] FAIL reset_hresp: got %b expected 0", HRESP); end
    checks++; if (PSEL !== '0) begin failures++; $display("[TB] FAIL reset_psel: got %h expected 0", PSEL); end
    checks++; if (PENABLE !== 1'b0) begin failures++; $display("[TB] FAIL reset_penable: got %b expected 0", PENABLE); end
    checks++; if (HRDATA !== 32'h0) begin failures++; $display("[TB] FAIL reset_hrdata: got %h expected 0", HRDATA); end
    checks++; if ({PADDR, PWDATA, PWRITE} !== 65'h0) begin failures++; $display("[TB] FAIL reset_apb_regs: got %h/%h/%b expected 0", PADDR, PWDATA, PWRITE); end
    model_hrdata = '0;
  endtask

  task automatic test_no_transfer();
    logic ok;
    ok = 1'b1;
    for (int n = 0; n < 12; n++) begin
      HSEL = 1'($urandom_range(0, 1));
      HTRANS = 2'($urandom_range(0, 3));
      HREADYIN = 1'($urandom_range(0, 1));
      HADDR = $urandom;
      if (HSEL && HREADYIN && HTRANS[1]) HTRANS[1] = 1'b0;
      @(negedge HCLK);
      if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || PSEL !== '0) ok = 1'b0;
    end
    HSEL = 1'b0;
    HREADYIN = 1'b1;
    checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL no_transfer: got activity=%b expected 0", !ok); end
  endtask

  task automatic test_write_zero_wait();
    obs_t o;
    run_xfer(32'h0000_0310, 1'b1, 32'hA5A5_0001, 0, 1'b0, 1'b0, 32'h0, o);
    checks++; if (o.psel_or !== 8'h08) begin failures++; $display("[TB] FAIL wr_psel: got %h expected 08", o.psel_or); end
    checks++; if (o.paddr !== 32'h0000_0310) begin failures++; $display("[TB] FAIL wr_paddr: got %h expected 00000310", o.paddr); end
    checks++; if (o.pwdata !== 32'hA5A5_0001) begin failures++; $display("[TB] FAIL wr_pwdata: got %h expected a5a50001", o.pwdata); end
    checks++; if (o.pwrite !== 1'b1) begin failures++; $display("[TB] FAIL wr_pwrite: got %b expected 1", o.pwrite); end
    checks++; if (o.pen_cycles !== 1) begin failures++; $display("[TB] FAIL wr_penable_cycles: got %0d expected 1", o.pen_cycles); end
    checks++; if (o.low !== 3) begin failures++; $display("[TB] FAIL wr_latency: got %0d expected 3", o.low); end
    checks++; if (o.resp_done !== 1'b0 || o.hrdata !== model_hrdata) begin failures++; $display("[TB] FAIL wr_resp_hrdata: got %b/%h expected 0/%h", o.resp_done, o.hrdata, model_hrdata); end
  endtask

  task automatic test_read_wait();
    obs_t o;
    run_xfer(32'h0000_0204, 1'b0, 32'h1234_5678, 3, 1'b0, 1'b0, 32'hDEAD_BEEF, o);
    checks++; if (o.low !== 6) begin failures++; $display("[TB] FAIL rd_wait_latency: got %0d expected 6", o.low); end
    checks++; if (o.hrdata !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL rd_wait_hrdata: got %h expected deadbeef", o.hrdata); end
    checks++; if (o.resp_done !== 1'b0 || o.psel_or !== 8'h04) begin failures++; $display("[TB] FAIL rd_wait_resp_psel: got %b/%h expected 0/04", o.resp_done, o.psel_or); end
    model_hrdata = 32'hDEAD_BEEF;
  endtask

  task automatic test_errors();
    obs_t o;
    run_xfer(32'h0000_0500, 1'b0, 32'h0, 1, 1'b0, 1'b1, 32'h5555_AAAA, o);
    checks++; if (o.low !== 5 || o.resp_err_low !== 1'b1 || o.resp_done !== 1'b1) begin failures++; $display("[TB] FAIL slverr_resp: got low=%0d resp=%b/%b expected 5 1/1", o.low, o.resp_err_low, o.resp_done); end
    checks++; if (o.hrdata !== model_hrdata) begin failures++; $display("[TB] FAIL slverr_hrdata: got %h expected %h", o.hrdata, model_hrdata); end
    run_xfer(32'h0000_0C00, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h7777_7777, o);
    checks++; if (o.low !== 2 || o.resp_err_low !== 1'b1 || o.resp_done !== 1'b1) begin failures++; $display("[TB] FAIL unmapped_resp: got low=%0d resp=%b/%b expected 2 1/1", o.low, o.resp_err_low, o.resp_done); end
    checks++; if (o.psel_or !== '0 || o.hrdata !== model_hrdata) begin failures++; $display("[TB] FAIL unmapped_psel_hrdata: got %h/%h expected 00/%h", o.psel_or, o.hrdata, model_hrdata); end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_xfer(32'h0000_0700, 1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h1111_2222, o);
    checks++; if (o.pen_cycles !== TO) begin failures++; $display("[TB] FAIL timeout_access_cycles: got %0d expected %0d", o.pen_cycles, TO); end
    checks++; if (o.low !== 3 + TO || o.resp_err_low !== 1'b1 || o.resp_done !== 1'b1) begin failures++; $display("[TB] FAIL timeout_resp: got low=%0d resp=%b/%b expected %0d 1/1", o.low, o.resp_err_low, o.resp_done, 3 + TO); end
    checks++; if (o.hrdata !== model_hrdata) begin failures++; $display("[TB] FAIL timeout_hrdata: got %h expected %h", o.hrdata, model_hrdata); end
    run_xfer(32'h0000_0010, 1'b1, 32'hCAFE_0000, 0, 1'b0, 1'b0, 32'h0, o);
    checks++; if (o.low !== 3 || o.resp_done !== 1'b0 || o.psel_or !== 8'h01) begin failures++; $display("[TB] FAIL after_timeout_write: got low=%0d resp=%b psel=%h expected 3 0 01", o.low, o.resp_done, o.psel_or); end
  endtask

  task automatic test_back_to_back();
    obs_t        o;
    logic [31:0] rd;
    rd = $urandom;
    run_xfer(32'h0000_0100, 1'b1, 32'h0BAD_F00D, 0, 1'b0, 1'b0, 32'h0, o);
    run_xfer(32'h0000_0604, 1'b0, 32'h0, 2, 1'b0, 1'b0, rd, o);
    checks++; if (o.dphase_low !== 1'b1 || o.low !== 5) begin failures++; $display("[TB] FAIL b2b_after_done: got dphase=%b low=%0d expected 1 5", o.dphase_low, o.low); end
    checks++; if (o.hrdata !== rd) begin failures++; $display("[TB] FAIL b2b_hrdata: got %h expected %h", o.hrdata, rd); end
    model_hrdata = rd;
    run_xfer(32'h0000_0900, 1'b1, 32'h0, 0, 1'b0, 1'b0, 32'h0, o);
    run_xfer(32'h0000_0000, 1'b0, 32'h0, 0, 1'b0, 1'b0, ~rd, o);
    checks++; if (o.dphase_low !== 1'b1 || o.low !== 3 || o.hrdata !== ~rd) begin failures++; $display("[TB] FAIL b2b_after_err2: got dphase=%b low=%0d hrdata=%h expected 1 3 %h", o.dphase_low, o.low, o.hrdata, ~rd); end
    model_hrdata = ~rd;
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    slv_stall = 1'b1;
    HSEL = 1'b1;
    HTRANS = 2'b10;
    HADDR = 32'h0000_0300;
    HWRITE = 1'b0;
    @(negedge HCLK);
    HSEL = 1'b0;
    HTRANS = 2'b00;
    for (int n = 0; n < 10 && !PENABLE; n++) @(negedge HCLK);
    checks++; if (PENABLE !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_reach_access: got %b expected 1", PENABLE); end
    @(negedge HCLK);
    HRESETN = 1'b0;
    @(negedge HCLK);
    checks++; if (PSEL !== '0 || PENABLE !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_apb: got psel=%h penable=%b expected 00 0", PSEL, PENABLE); end
    checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin failures++; $display("[TB] FAIL rst_mid_ahb: got %b/%b/%h expected 1/0/0", HREADYOUT, HRESP, HRDATA); end
    HRESETN = 1'b1;
    slv_stall = 1'b0;
    model_hrdata = '0;
    @(negedge HCLK);
    run_xfer(32'h0000_0400, 1'b1, 32'h600D_600D, 0, 1'b0, 1'b0, 32'h0, o);
    checks++; if (o.low !== 3 || o.resp_done !== 1'b0 || o.psel_or !== 8'h10) begin failures++; $display("[TB] FAIL rst_mid_recover: got low=%0d resp=%b psel=%h expected 3 0 10", o.low, o.resp_done, o.psel_or); end
  endtask

  task automatic test_random();
    obs_t        o, e;
    logic [31:0] addr, wd, rd;
    logic        wr, err, stall;
    int          waits;
    for (int i = 0; i < 40; i++) begin
      addr = $urandom;
      addr[LSB+3:LSB] = 4'($urandom_range(0, 11));
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      rd = $urandom;
      waits = $urandom_range(0, 5);
      err = ($urandom_range(0, 3) == 0);
      stall = ($urandom_range(0, 9) == 0);
      e = model_xfer(addr, wr, wd, waits, stall, err, rd);
      run_xfer(addr, wr, wd, waits, stall, err, rd, o);
      checks++; if (o.low !== e.low) begin failures++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", i, o.low, e.low); end
      checks++; if (o.dphase_low !== e.dphase_low) begin failures++; $display("[TB] FAIL rand_dphase[%0d]: got %b expected %b", i, o.dphase_low, e.dphase_low); end
      checks++; if ({o.resp_err_low, o.resp_done} !== {e.resp_err_low, e.resp_done}) begin failures++; $display("[TB] FAIL rand_hresp[%0d]: got %b%b expected %b%b", i, o.resp_err_low, o.resp_done, e.resp_err_low, e.resp_done); end
      checks++; if (o.psel_or !== e.psel_or) begin failures++; $display("[TB] FAIL rand_psel[%0d]: got %h expected %h", i, o.psel_or, e.psel_or); end
      checks++; if (o.pen_cycles !== e.pen_cycles) begin failures++; $display("[TB] FAIL rand_penable[%0d]: got %0d expected %0d", i, o.pen_cycles, e.pen_cycles); end
      checks++; if ({o.paddr, o.pwrite} !== {e.paddr, e.pwrite}) begin failures++; $display("[TB] FAIL rand_paddr[%0d]: got %h/%b expected %h/%b", i, o.paddr, o.pwrite, e.paddr, e.pwrite); end
      checks++; if (o.pwdata !== e.pwdata) begin failures++; $display("[TB] FAIL rand_pwdata[%0d]: got %h expected %h", i, o.pwdata, e.pwdata); end
      checks++; if (o.hrdata !== e.hrdata) begin failures++; $display("[TB] FAIL rand_hrdata[%0d]: got %h expected %h", i, o.hrdata, e.hrdata); end
      model_hrdata = e.hrdata;
    end
  endtask

  initial begin
    test_reset();
    test_no_transfer();
    test_write_zero_wait();
    test_read_wait();
    test_errors();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    HSEL = 1'b0;
    HTRANS = 2'b00;
    repeat (2) @(negedge HCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule

// File: doc/ahbl_apb_bridge_mslot.md
# ahbl_apb_bridge_mslot

Parametrised AHB-Lite slave to APB3 master bridge for the BFM-based test harness. It sits behind one HSEL line of the AHB-Lite BFM and fans accesses out to up to 16 APB slots decoded from HADDR. It replaces the fixed-slot bridge with these additions:
- configurable slot count and decode position;
- PREADY wait states;
- PSLVERR-to-HRESP error mapping;
- an error response for unmapped slots;
- an optional PREADY timeout.

## Interface
Parameters:
- NUM_SLOTS, 16, number of APB slots, 1..16; width of PSEL.
- SLOT_LSB, 8, slot index = HADDR[SLOT_LSB+3:SLOT_LSB]; legal 2..27.
- TIMEOUT, 0, maximum ACCESS cycles with PREADY low before forced error; 0 disables, otherwise 1..65535.

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESETN  in  1  reset, synchronous, active-low.
- HSEL  in  1  bridge select.
- HADDR  in  32  AHB address.
- HWRITE  in  1  AHB write.
- HTRANS  in  2  AHB transfer type; bit 1 set = NONSEQ/SEQ.
- HSIZE  in  3  accepted, ignored; full word always transferred.
- HWDATA  in  32  AHB write data, valid the cycle after the address phase.
- HREADYIN  in  1  bus-level HREADY.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- PSEL  out  NUM_SLOTS  one-hot APB select.
- PADDR  out  32  APB address.
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB enable.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data, from the muxed selected slot.
- PREADY  in  1  APB ready, from the muxed selected slot.
- PSLVERR  in  1  APB error, from the muxed selected slot.

## Operation
- All outputs are registered.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, timeout counter=0, state=IDLE.
- Accept condition: HSEL & HREADYIN & HTRANS[1], sampled only in states IDLE, DONE and ERR2. On accept, capture HADDR, HWRITE and the slot index, then go to DPHASE.
- HSEL with IDLE/BUSY HTRANS, or HSEL low: no transfer; HREADYOUT stays 1 and HRESP stays 0.
- DPHASE: HREADYOUT=0; capture HWDATA into PWDATA. If the slot index is below NUM_SLOTS, go to SETUP; otherwise go to ERR1 and issue no APB access.
- SETUP: PSEL[index]=1, PENABLE=0, PADDR = captured HADDR, PWRITE = captured HWRITE. Go to ACCESS.
- ACCESS: PENABLE=1, PSEL held.
  - PREADY=1 & PSLVERR=0: HRDATA<=PRDATA on a read (HRDATA unchanged on a write), then go to DONE.
  - PREADY=1 & PSLVERR=1: go to ERR1.
  - PREADY=0: increment the counter. If TIMEOUT≠0 and the counter reaches TIMEOUT, go to ERR1.
  - Every ACCESS exit: PSEL=0, PENABLE=0, counter cleared.
- DONE: HREADYOUT=1, HRESP=0. Accept a new transfer (to DPHASE), else go to IDLE.
- ERR1: HREADYOUT=0, HRESP=1. Go to ERR2.
- ERR2: HREADYOUT=1, HRESP=1. Accept a new transfer (to DPHASE), else go to IDLE.
- A read that errors leaves HRDATA unchanged.
- HRESETN low at any rising edge, including mid-ACCESS, forces the reset values on the next cycle. The APB access is abandoned with no completion.
- PADDR, PWRITE and PWDATA hold their last values while idle.

## Timing
- Address phase accepted in cycle 0:
  - cycle 1: DPHASE;
  - cycle 2: SETUP;
  - cycle 3: ACCESS;
  - cycle 4: DONE, HREADYOUT=1.
- Zero-wait transfer: HREADYOUT low for 3 cycles.
- Each PREADY-low cycle in ACCESS adds 1 cycle.
- Error: ERROR completes at the ERR2 cycle.
  - Unmapped slot: ERR1 in cycle 2, ERR2 in cycle 3.
  - PSLVERR at a zero-wait ACCESS: ERR1 in cycle 4, ERR2 in cycle 5.
- Timeout with TIMEOUT=N: ERR1 follows exactly N consecutive PREADY-low ACCESS cycles.
- Back-to-back: a transfer accepted in DONE or ERR2 enters DPHASE on the next cycle, with no idle gap.

## Test plan
- Reset with HRESETN=0 for 2 cycles, then release -> HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0, HRDATA=0.
- Write 0xA5A5_0001 to HADDR=0x0000_0310, SLOT_LSB=8, PREADY=1 -> PSEL=0x0008, PADDR=0x310, PWDATA=0xA5A5_0001, PENABLE high for 1 cycle, HREADYOUT=1 at cycle 4, HRESP=0.
- Read slot 2 with PREADY low for 3 cycles and PRDATA=0xDEAD_BEEF -> HREADYOUT low 6 cycles, then HRDATA=0xDEAD_BEEF with OKAY.
- Read with PSLVERR=1 at PREADY; separately, HADDR slot 12 with NUM_SLOTS=8 -> two-cycle ERROR (HREADYOUT 0 then 1, HRESP=1 both cycles), HRDATA unchanged; for slot 12, PSEL stays 0.
- TIMEOUT=4 with PREADY stuck low -> PSEL/PENABLE drop after 4 ACCESS cycles, then ERR1/ERR2. A following write to slot 0 completes OKAY.
- Back-to-back write then read accepted in DONE, and HRESETN pulsed low mid-ACCESS -> no gap between transfers; after the reset edge, PSEL=0 and the FSM is in IDLE.
